// File: rtl/boil_fsm.sv
// rtl/boil_fsm.sv - brew kettle boil sequencer: fill, heat, timed boil with hop drops, chill, transfer
module boil_fsm #(
    parameter int T_BOIL     = 100,
    parameter int T_HOLD     = 98,
    parameter int T_PITCH    = 20,
    parameter int T_FAULT    = 110,
    parameter int L_BOIL     = 175,
    parameter int BOIL_TICKS = 60,
    parameter int AROMA_AT   = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       tick,
    input  logic [7:0] temp,
    input  logic [7:0] level,
    output logic       heat,
    output logic       chill,
    output logic       pump_out,
    output logic [1:0] hop,
    output logic       done,
    output logic       fault,
    output logic [3:0] state
);

    localparam logic [7:0] TB_L  = T_BOIL[7:0];
    localparam logic [7:0] TH_L  = T_HOLD[7:0];
    localparam logic [7:0] TP_L  = T_PITCH[7:0];
    localparam logic [7:0] TF_L  = T_FAULT[7:0];
    localparam logic [7:0] LB_L  = L_BOIL[7:0];
    localparam logic [7:0] BT_L  = BOIL_TICKS[7:0];
    localparam logic [7:0] AA_L  = AROMA_AT[7:0];

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WAIT_FILL = 4'd1,
        S_HEAT_UP   = 4'd2,
        S_BOIL      = 4'd3,
        S_CHILL     = 4'd4,
        S_TRANSFER  = 4'd5,
        S_DONE      = 4'd6,
        S_FAULT     = 4'd7
    } state_t;

    state_t     cur, nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       aroma_done, aroma_nxt;
    logic [1:0] hop_nxt;
    logic       over;

    assign over = temp > TF_L;

    always_comb begin
        nxt       = cur;
        cnt_nxt   = cnt;
        aroma_nxt = aroma_done;
        hop_nxt   = 2'b00;
        case (cur)
            S_IDLE:      if (start) nxt = S_WAIT_FILL;
            S_WAIT_FILL: if (level >= LB_L) nxt = S_HEAT_UP;
            S_HEAT_UP: begin
                if (over) begin
                    nxt = S_FAULT;
                end else if (temp >= TB_L) begin
                    nxt       = S_BOIL;
                    cnt_nxt   = 8'd0;
                    aroma_nxt = 1'b0;
                    hop_nxt   = 2'b01;
                end
            end
            S_BOIL: begin
                // Exit is checked before counting, so a tick on the exit cycle is dropped
                if (over) begin
                    nxt = S_FAULT;
                end else if (cnt == BT_L) begin
                    nxt = S_CHILL;
                end else begin
                    if (tick && temp >= TH_L) cnt_nxt = cnt + 8'd1;
                    if (cnt == AA_L && !aroma_done) begin
                        hop_nxt   = 2'b10;
                        aroma_nxt = 1'b1;
                    end
                end
            end
            S_CHILL:     if (temp <= TP_L) nxt = S_TRANSFER;
            S_TRANSFER:  if (level == 8'd0) nxt = S_DONE;
            S_DONE:      nxt = S_IDLE;
            S_FAULT:     nxt = S_FAULT;
            default:     nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur        <= S_IDLE;
            cnt        <= 8'd0;
            aroma_done <= 1'b0;
            hop        <= 2'b00;
        end else begin
            cur        <= nxt;
            cnt        <= cnt_nxt;
            aroma_done <= aroma_nxt;
            hop        <= hop_nxt;
        end
    end

    assign heat     = (cur == S_HEAT_UP) || (cur == S_BOIL);
    assign chill    = (cur == S_CHILL);
    assign pump_out = (cur == S_TRANSFER);
    assign done     = (cur == S_DONE);
    assign fault    = (cur == S_FAULT);
    assign state    = cur;

endmodule

// File: doc/boil_fsm.md
BOIL_FSM -- requirements
Module: boil_fsm

Interface
REQ-001 SHALL have parameter T_BOIL, default 100, boil temperature threshold in degrees.
REQ-002 SHALL have parameter T_HOLD, default 98, minimum temperature at which the boil timer advances.
REQ-003 SHALL have parameter T_PITCH, default 20, chill-complete temperature.
REQ-004 SHALL have parameter T_FAULT, default 110, overtemperature limit.
REQ-005 SHALL have parameter L_BOIL, default 175, kettle level required to start heating.
REQ-006 SHALL have parameter BOIL_TICKS, default 60, boil duration in ticks.
REQ-007 SHALL have parameter AROMA_AT, default 50, tick count at which aroma hops drop; 0 < AROMA_AT < BOIL_TICKS.
REQ-008 SHALL have ports: clk  in  1  single clock, all logic on posedge.
REQ-009 reset  in  1  synchronous, active-high.
REQ-010 start  in  1  one-cycle pulse from the mash stage when wort transfer to the kettle begins.
REQ-011 tick  in  1  one-cycle time-base strobe (one per minute).
REQ-012 temp  in  8  kettle temperature, unsigned degrees.
REQ-013 level  in  8  kettle level, unsigned.
REQ-014 heat  out  1  kettle heater on.
REQ-015 chill  out  1  wort chiller on.
REQ-016 pump_out  out  1  pump kettle to fermenter.
REQ-017 hop  out  2  hop chute pulses: bit0 bittering, bit1 aroma.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 fault  out  1  overtemperature latched.
REQ-020 state  out  4  current state code.

Function
REQ-021 SHALL implement states IDLE=0, WAIT_FILL=1, HEAT_UP=2, BOIL=3, CHILL=4, TRANSFER=5, DONE=6, FAULT=7, driven on state.
REQ-022 SHALL be a registered Moore machine: a condition sampled at edge N changes state and outputs at edge N+1.
REQ-023 IDLE: start=1 -> WAIT_FILL; otherwise hold; start SHALL be ignored in every other state.
REQ-024 WAIT_FILL: level >= L_BOIL -> HEAT_UP.
REQ-025 HEAT_UP: temp >= T_BOIL -> BOIL, clearing the 8-bit boil counter to 0.
REQ-026 BOIL: counter SHALL increment on tick only while temp >= T_HOLD; tick with temp < T_HOLD SHALL not count.
REQ-027 BOIL: counter == BOIL_TICKS -> CHILL; counter SHALL saturate at BOIL_TICKS and never wrap.
REQ-028 CHILL: temp <= T_PITCH -> TRANSFER.
REQ-029 TRANSFER: level == 0 -> DONE.
REQ-030 DONE SHALL last one cycle, then -> IDLE.
REQ-031 heat SHALL be 1 only in HEAT_UP and BOIL; chill only in CHILL; pump_out only in TRANSFER; done only in DONE; fault only in FAULT.
REQ-032 hop[0] SHALL pulse exactly one cycle, on the first cycle in BOIL.
REQ-033 hop[1] SHALL pulse exactly one cycle, on the first cycle after the counter becomes AROMA_AT, once per boil even if temp dips.
REQ-034 hop bits SHALL never both be 1 in the same cycle.
REQ-035 temp > T_FAULT in HEAT_UP or BOIL SHALL -> FAULT, taking priority over every other transition that cycle.
REQ-036 FAULT SHALL hold with all outputs except fault and state at 0 until reset.
REQ-037 A tick coinciding with the BOIL exit cycle SHALL have no effect.

Reset
REQ-038 reset=1 at any posedge SHALL force IDLE, counter 0, and heat/chill/pump_out/hop/done/fault = 0 at the next cycle, mid-operation included.
REQ-039 reset SHALL take priority over start, tick and fault detection.

Verification
REQ-040 Nominal run: start, level 180, temp 100, 60 qualified ticks, temp 20, level 0 -> states 1,2,3,4,5,6,0; hop[0] once at BOIL entry; hop[1] after tick 50; done one cycle.
REQ-041 Boil dip: temp 95 during ticks 10-14 -> those 5 ticks not counted; BOIL lasts 65 ticks.
REQ-042 Overtemp: temp 111 in HEAT_UP -> FAULT next cycle, heat 0, fault 1; start ignored; holds until reset.
REQ-043 Reset mid-BOIL at counter 30 -> IDLE next cycle, all outputs 0; new start reruns from WAIT_FILL with counter 0.
REQ-044 Boundary: level 174 holds WAIT_FILL, 175 advances; temp 99 holds HEAT_UP, 100 advances; temp 21 holds CHILL, 20 advances.
REQ-045 start pulsed in BOIL -> no state change; tick in IDLE -> no effect.
